// File: rtl/alu_pkg.sv
// Shared types for the CB-prefix shift/rotate sequencer
// and the ALU control-line bundle it drives.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    OP_RLC, OP_RRC, OP_RL, OP_RR,
    OP_SLA, OP_SRA, OP_SWAP, OP_SRL
  } shift_op_t;

  typedef enum logic [1:0] {
    NO_SH, L_SH, R_SH, SW_SH
  } alu_sh_t;

  typedef enum logic [1:0] {
    NO_OE, SH_OE, RES_OE
  } alu_oe_t;

  typedef enum logic {
    NO_LD, BUS_LD
  } alu_ld_t;

  typedef struct packed {
    logic [ALU_W-1:0] op;
    logic             si;
    alu_sh_t          sh;
    alu_oe_t          oe;
    alu_ld_t          la;
    alu_ld_t          lb;
    logic             r;
    logic             s;
    logic             v;
    logic             ne;
    logic             ci;
    logic             l;
    logic             h;
  } alu_line_t;

  localparam alu_line_t ALU_LINE_IDLE = '{
    op: '0, si: 1'b0, sh: NO_SH, oe: NO_OE,
    la: NO_LD, lb: NO_LD,
    r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0,
    ci: 1'b0, l: 1'b0, h: 1'b0
  };

endpackage

// File: rtl/alu_shift_decode.sv
// Per-opcode shift-in bit, shift direction and the carry
// the ALU is expected to shift out.
module alu_shift_decode
  import alu_pkg::*;
(
  input  shift_op_t        op_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic             cin_i,
  output logic             si_o,
  output alu_sh_t          sh_o,
  output logic             cy_o
);

  always_comb begin
    si_o = 1'b0;
    sh_o = NO_SH;
    cy_o = 1'b0;
    unique case (op_i)
      OP_RLC: begin
        si_o = b_i[7];
        sh_o = L_SH;
        cy_o = b_i[7];
      end
      OP_RRC: begin
        si_o = b_i[0];
        sh_o = R_SH;
        cy_o = b_i[0];
      end
      OP_RL: begin
        si_o = cin_i;
        sh_o = L_SH;
        cy_o = b_i[7];
      end
      OP_RR: begin
        si_o = cin_i;
        sh_o = R_SH;
        cy_o = b_i[0];
      end
      OP_SLA: begin
        sh_o = L_SH;
        cy_o = b_i[7];
      end
      OP_SRA: begin
        si_o = b_i[7];
        sh_o = R_SH;
        cy_o = b_i[0];
      end
      OP_SWAP: begin
        sh_o = SW_SH;
      end
      OP_SRL: begin
        sh_o = R_SH;
        cy_o = b_i[0];
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Two-line ALU micro-sequence for one shift/rotate request,
// returning result and {Z,N,H,C} over a valid/ready response.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic [W-1:0] alu_op,
  output logic         alu_si,
  output logic [1:0]   alu_sh,
  output logic [1:0]   alu_oe,
  output logic         alu_la,
  output logic         alu_lb,
  output logic         alu_r,
  output logic         alu_s,
  output logic         alu_v,
  output logic         alu_ne,
  output logic         alu_ci,
  output logic         alu_l,
  output logic         alu_h,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_shift_dbh,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         err
);

  if (W != 8) begin : g_w_chk
    $error("alu_shift_seq supports only W=8");
  end

  typedef enum logic [1:0] {
    ST_IDLE, ST_LINE1, ST_LINE2, ST_DONE
  } state_t;

  state_t    state_q, state_d;
  shift_op_t op_q, op_d;
  logic [W-1:0] b_q, b_d;
  logic      cin_q, cin_d;
  logic      cy_q, cy_d;
  logic [W-1:0] res_q, res_d;
  logic [3:0] flags_q, flags_d;
  logic      err_q, err_d;
  alu_line_t line;

  shift_op_t    dec_op;
  logic [W-1:0] dec_b;
  logic         dec_cin;
  logic         dec_si;
  alu_sh_t      dec_sh;
  logic         dec_cy;

  // Decode the live request while idle, the captured one after.
  assign dec_op  = (state_q == ST_IDLE) ? shift_op_t'(req_op) : op_q;
  assign dec_b   = (state_q == ST_IDLE) ? req_b : b_q;
  assign dec_cin = (state_q == ST_IDLE) ? req_cin : cin_q;

  alu_shift_decode u_dec (
    .op_i  (dec_op),
    .b_i   (dec_b),
    .cin_i (dec_cin),
    .si_o  (dec_si),
    .sh_o  (dec_sh),
    .cy_o  (dec_cy)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    cin_d   = cin_q;
    cy_d    = cy_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    line    = ALU_LINE_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = shift_op_t'(req_op);
          b_d     = req_b;
          cin_d   = req_cin;
          cy_d    = dec_cy;
          state_d = ST_LINE1;
        end
      end
      ST_LINE1: begin
        line.op = b_q;
        line.si = dec_si;
        line.sh = dec_sh;
        line.oe = SH_OE;
        line.la = BUS_LD;
        line.lb = BUS_LD;
        line.r  = 1'b1;
        line.s  = 1'b1;
        line.v  = 1'b1;
        line.l  = 1'b1;
        if (op_q != OP_SWAP && alu_shift_dbh != cy_q)
          err_d = 1'b1;
        state_d = ST_LINE2;
      end
      ST_LINE2: begin
        line.oe = RES_OE;
        line.r  = 1'b1;
        line.s  = 1'b1;
        line.v  = 1'b1;
        line.h  = 1'b1;
        res_d   = alu_result;
        flags_d = {alu_zero, 1'b0, 1'b0, cy_q};
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RLC;
      b_q     <= '0;
      cin_q   <= 1'b0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign err        = err_q;

  assign alu_op = line.op;
  assign alu_si = line.si;
  assign alu_sh = line.sh;
  assign alu_oe = line.oe;
  assign alu_la = line.la;
  assign alu_lb = line.lb;
  assign alu_r  = line.r;
  assign alu_s  = line.s;
  assign alu_v  = line.v;
  assign alu_ne = line.ne;
  assign alu_ci = line.ci;
  assign alu_l  = line.l;
  assign alu_h  = line.h;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: a behavioural ALU answers the line
// bundle; results are compared with a rotate/shift reference.
module tb_alu_shift_seq;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_b;
  logic       req_cin;
  logic [7:0] alu_op;
  logic       alu_si;
  logic [1:0] alu_sh;
  logic [1:0] alu_oe;
  logic       alu_la, alu_lb;
  logic       alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_shift_dbh;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       err;

  int checks = 0;
  int errors = 0;

  alu_shift_seq #(.W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_b         (req_b),
    .req_cin       (req_cin),
    .alu_op        (alu_op),
    .alu_si        (alu_si),
    .alu_sh        (alu_sh),
    .alu_oe        (alu_oe),
    .alu_la        (alu_la),
    .alu_lb        (alu_lb),
    .alu_r         (alu_r),
    .alu_s         (alu_s),
    .alu_v         (alu_v),
    .alu_ne        (alu_ne),
    .alu_ci        (alu_ci),
    .alu_l         (alu_l),
    .alu_h         (alu_h),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_shift_dbh (alu_shift_dbh),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: shifter on the bus, result latched for line 2
  logic [7:0] shv;
  logic       shout;
  logic [7:0] alu_lat = 8'h00;
  logic       force_en = 1'b0;
  logic       force_val = 1'b0;

  always_comb begin
    shv   = alu_op;
    shout = 1'b0;
    case (alu_sh)
      2'd1: begin shv = {alu_op[6:0], alu_si}; shout = alu_op[7]; end
      2'd2: begin shv = {alu_si, alu_op[7:1]}; shout = alu_op[0]; end
      2'd3: begin shv = {alu_op[3:0], alu_op[7:4]}; end
      default: ;
    endcase
  end

  always @(posedge clk)
    if (alu_oe == 2'b01) alu_lat <= shv;

  assign alu_shift_dbh = (alu_oe == 2'b01) ?
                         (force_en ? force_val : shout) : 1'b0;
  assign alu_result = (alu_oe == 2'b10) ? alu_lat : 8'h00;
  assign alu_zero   = (alu_oe == 2'b10) && (alu_lat == 8'h00);

  logic [21:0] bus;
  assign bus = {alu_op, alu_si, alu_sh, alu_oe, alu_la, alu_lb,
                alu_r, alu_s, alu_v, alu_ne, alu_ci, alu_l, alu_h};

  localparam logic [21:0] LINE2_BUS =
    {8'h00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0,
     1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {sh, si, carry, result} from the opcode rules
  function automatic logic [11:0] ref_model(input int op, input int b,
                                            input int cin);
    int r, c, si, sh;
    logic [11:0] v;
    case (op)
      0: begin r = (b << 1) | (b >> 7);     c = b >> 7; si = b >> 7; sh = 1; end
      1: begin r = (b >> 1) | ((b & 1) << 7); c = b & 1; si = b & 1;  sh = 2; end
      2: begin r = (b << 1) | cin;           c = b >> 7; si = cin;    sh = 1; end
      3: begin r = (b >> 1) | (cin << 7);    c = b & 1; si = cin;    sh = 2; end
      4: begin r = b << 1;                   c = b >> 7; si = 0;      sh = 1; end
      5: begin r = (b >> 1) | (b & 128);     c = b & 1; si = b >> 7; sh = 2; end
      6: begin r = (b << 4) | (b >> 4);      c = 0;     si = 0;      sh = 3; end
      default: begin r = b >> 1;             c = b & 1; si = 0;      sh = 2; end
    endcase
    r = r & 255;
    v = {sh[1:0], si[0], c[0], r[7:0]};
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] b,
                     input logic cin, input logic [7:0] er,
                     input logic [3:0] ef, input logic esi,
                     input logic [1:0] esh);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_b     = b;
    req_cin   = cin;
    @(negedge clk);
    req_valid = 1'b0;
    req_b     = ~b;
    req_cin   = ~cin;
    req_op    = op + 3'd1;
    chk("line1_bus", bus, {b, esi, esh, 2'b01, 1'b1, 1'b1,
                           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("line1_ready", req_ready, 0);
    @(negedge clk);
    chk("line2_bus", bus, LINE2_BUS);
    chk("line2_valid", rsp_valid, 0);
    @(negedge clk);
    chk("done_valid", rsp_valid, 1);
    chk("done_result", rsp_result, er);
    chk("done_flags", rsp_flags, ef);
    chk("done_bus_idle", bus, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_hs_valid", rsp_valid, 0);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] flags;
    logic       si;
    logic [1:0] sh;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'd0, 8'h85, 1'b0, 8'h0B, 4'b0001, 1'b1, 2'd1};
    vecs[1] = '{3'd3, 8'h01, 1'b1, 8'h80, 4'b0001, 1'b1, 2'd2};
    vecs[2] = '{3'd7, 8'h01, 1'b0, 8'h00, 4'b1001, 1'b0, 2'd2};
    vecs[3] = '{3'd6, 8'hA5, 1'b1, 8'h5A, 4'b0000, 1'b0, 2'd3};
    vecs[4] = '{3'd5, 8'h81, 1'b0, 8'hC0, 4'b0001, 1'b1, 2'd2};
    vecs[5] = '{3'd4, 8'h80, 1'b1, 8'h00, 4'b1001, 1'b0, 2'd1};

    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_b = 8'h00;
    req_cin = 1'b0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_err", err, 0);
    chk("rst_bus", bus, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].op, vecs[i].b, vecs[i].cin, vecs[i].res,
          vecs[i].flags, vecs[i].si, vecs[i].sh);
      chk("vec_err", err, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [7:0]  b;
      logic        cin;
      logic [11:0] m;
      op  = 3'($urandom_range(0, 7));
      b   = 8'($urandom);
      cin = 1'($urandom);
      m   = ref_model(int'(op), int'(b), int'(cin));
      run(op, b, cin, m[7:0], {m[7:0] == 8'h00, 2'b00, m[8]},
          m[9], m[11:10]);
    end
    chk("rand_err", err, 0);

    // Backpressure with a competing request held on req_valid
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_op = 3'd7;
    req_b = 8'h02;
    req_cin = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd0;
    req_b = 8'h85;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 8'h01);
      chk("bp_flags", rsp_flags, 4'b0000);
      chk("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_bus", bus, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_line1_bus", bus, {8'h85, 1'b1, 2'd1, 2'b01, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    chk("bp2_result", rsp_result, 8'h0B);
    chk("bp2_flags", rsp_flags, 4'b0001);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Shifted-out bit disagrees with the expected carry
    force_en = 1'b1;
    force_val = 1'b0;
    run(3'd0, 8'h80, 1'b0, 8'h01, 4'b0001, 1'b1, 2'd1);
    force_en = 1'b0;
    chk("err_set", err, 1);
    run(3'd2, 8'h40, 1'b1, 8'h81, 4'b0000, 1'b1, 2'd1);
    chk("err_sticky", err, 1);

    // Reset while in LINE2
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_op = 3'd2;
    req_b = 8'hFF;
    req_cin = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_line2", bus, LINE2_BUS);
    #1 reset = 1'b1;
    #1;
    chk("midrst_bus", bus, 0);
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_valid", rsp_valid, 0);
      chk("postrst_ready", req_ready, 1);
    end
    run(3'd1, 8'h03, 1'b0, 8'h81, 4'b0001, 1'b1, 2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
